// File: rtl/disp_bcd_formatter_pkg.sv
// Shared constants and state encoding for the BCD display formatter and the
// display controller top that instantiates it.
package disp_bcd_formatter_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int MAX_VAL    = 9999;
  localparam logic [NUM_DIGITS-1:0] ERR_ALL = 4'b1111;

  // Blank pattern that leaves a single visible 0 on dig0.
  localparam logic [NUM_DIGITS-1:0] BLANK_IDLE = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_t;

endpackage

// File: rtl/disp_bcd_formatter_if.sv
// Request/result bundle between the calculator core and the BCD formatter.
interface disp_bcd_formatter_if #(
  parameter int WIDTH = 14
);
  import disp_bcd_formatter_pkg::*;

  logic                  start;
  logic [WIDTH-1:0]      value;
  logic [1:0]            dp_pos;
  logic                  err_in;
  logic                  busy;
  logic                  done;
  logic [3:0]            dig0;
  logic [3:0]            dig1;
  logic [3:0]            dig2;
  logic [3:0]            dig3;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] dec_point;
  logic [NUM_DIGITS-1:0] error;

  modport master (
    output start, value, dp_pos, err_in,
    input  busy, done, dig0, dig1, dig2, dig3, blank, dec_point, error
  );

  modport slave (
    input  start, value, dp_pos, err_in,
    output busy, done, dig0, dig1, dig2, dig3, blank, dec_point, error
  );

endinterface

// File: rtl/disp_bcd_formatter_bcd_add3.sv
// Double-dabble nibble correction: add 3 to any BCD nibble of 5 or more so the
// following left shift carries correctly into the next decade.
module bcd_add3 (
  input  logic [3:0] nibble_in,
  output logic [3:0] nibble_out
);

  assign nibble_out = (nibble_in >= 4'd5) ? (nibble_in + 4'd3) : nibble_in;

endmodule

// File: rtl/disp_bcd_formatter.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero blanking,
// decimal point and error formatting; outputs only change on the done pulse.
module disp_bcd_formatter #(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = disp_bcd_formatter_pkg::MAX_VAL
) (
  input  logic                 clk,
  input  logic                 reset,
  disp_bcd_formatter_if.slave  bus
);
  import disp_bcd_formatter_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  state_t                           state_reg, state_next;
  logic [WIDTH-1:0]                 bin_reg, bin_next;
  // Four BCD nibbles plus a sticky guard bit above the thousands digit.
  logic [16:0]                      bcd_reg, bcd_next;
  logic [CNT_W-1:0]                 cnt_reg, cnt_next;
  logic [1:0]                       dp_reg, dp_next;
  logic                             err_reg, err_next;
  logic                             busy_reg, busy_next;
  logic                             done_reg, done_next;
  logic [NUM_DIGITS-1:0][3:0]       dig_reg, dig_next;
  logic [NUM_DIGITS-1:0]            blank_reg, blank_next;
  logic [NUM_DIGITS-1:0]            dp_out_reg, dp_out_next;
  logic [NUM_DIGITS-1:0]            error_reg, error_next;

  logic [15:0]                      bcd_corr;
  logic [NUM_DIGITS-1:0]            blank_fmt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .nibble_in  (bcd_reg[4*gi +: 4]),
        .nibble_out (bcd_corr[4*gi +: 4])
      );

      // A digit blanks only when it and everything above it is zero and it
      // sits strictly left of the decimal point; dig0 always shows.
      if (gi == 0) begin : g_first
        assign blank_fmt[gi] = 1'b0;
      end else begin : g_upper
        assign blank_fmt[gi] = (2'(gi) > dp_reg) && (bcd_reg[15:4*gi] == '0);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      bin_reg    <= '0;
      bcd_reg    <= '0;
      cnt_reg    <= '0;
      dp_reg     <= '0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dig_reg    <= '0;
      blank_reg  <= BLANK_IDLE;
      dp_out_reg <= '0;
      error_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      bin_reg    <= bin_next;
      bcd_reg    <= bcd_next;
      cnt_reg    <= cnt_next;
      dp_reg     <= dp_next;
      err_reg    <= err_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
      dig_reg    <= dig_next;
      blank_reg  <= blank_next;
      dp_out_reg <= dp_out_next;
      error_reg  <= error_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    bin_next    = bin_reg;
    bcd_next    = bcd_reg;
    cnt_next    = cnt_reg;
    dp_next     = dp_reg;
    err_next    = err_reg;
    done_next   = 1'b0;
    dig_next    = dig_reg;
    blank_next  = blank_reg;
    dp_out_next = dp_out_reg;
    error_next  = error_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          bin_next   = bus.value;
          dp_next    = bus.dp_pos;
          // Range is judged on the binary input, never on the BCD result.
          err_next   = bus.err_in || (bus.value > WIDTH'(MAX_VAL));
          bcd_next   = '0;
          cnt_next   = CNT_W'(WIDTH - 1);
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        bcd_next = {bcd_reg[16] | bcd_corr[15], bcd_corr[14:0], bin_reg[WIDTH-1]};
        bin_next = {bin_reg[WIDTH-2:0], 1'b0};
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == '0) begin
          state_next = ST_FORMAT;
        end
      end

      ST_FORMAT: begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
        if (err_reg) begin
          dig_next    = '0;
          blank_next  = '0;
          dp_out_next = '0;
          error_next  = ERR_ALL;
        end else begin
          dig_next    = bcd_reg[15:0];
          blank_next  = blank_fmt;
          dp_out_next = (dp_reg == 2'd0) ? '0 : (4'b0001 << dp_reg);
          error_next  = '0;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.dig0      = dig_reg[0];
  assign bus.dig1      = dig_reg[1];
  assign bus.dig2      = dig_reg[2];
  assign bus.dig3      = dig_reg[3];
  assign bus.blank     = blank_reg;
  assign bus.dec_point = dp_out_reg;
  assign bus.error     = error_reg;

endmodule

// File: tb/tb_disp_bcd_formatter.sv
// Self-checking bench: vector table feeding a scoreboard that is drained on each
// done pulse, plus hand sequences for busy, back-to-back and reset corner cases.
module tb_disp_bcd_formatter;

  typedef struct {
    logic [13:0] value;
    logic [1:0]  dp;
    logic        err;
    logic [15:0] digs;   // {dig3, dig2, dig1, dig0}
    logic [3:0]  blank;
    logic [3:0]  dpv;
    logic [3:0]  errv;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  vec_t sb_q[$];
  vec_t vecs[10];

  disp_bcd_formatter_if #(.WIDTH(14)) bus ();

  disp_bcd_formatter #(.WIDTH(14), .MAX_VAL(9999)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard drain: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        $display("txn value=%0d dp=%0d err=%0b -> digits=%h%h%h%h blank=%b dp=%b error=%b",
                 e.value, e.dp, e.err, bus.dig3, bus.dig2, bus.dig1, bus.dig0,
                 bus.blank, bus.dec_point, bus.error);
        check($sformatf("digits_%0d", e.value), 32'({bus.dig3, bus.dig2, bus.dig1, bus.dig0}), 32'(e.digs));
        check($sformatf("blank_%0d", e.value), 32'(bus.blank), 32'(e.blank));
        check($sformatf("dec_point_%0d", e.value), 32'(bus.dec_point), 32'(e.dpv));
        check($sformatf("error_%0d", e.value), 32'(bus.error), 32'(e.errv));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_digits"}, 32'({bus.dig3, bus.dig2, bus.dig1, bus.dig0}), 32'h0);
    check({tag, "_blank"}, 32'(bus.blank), 32'b1110);
    check({tag, "_dec_point"}, 32'(bus.dec_point), 32'h0);
    check({tag, "_error"}, 32'(bus.error), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic drive_start(input vec_t v);
    bus.start  = 1'b1;
    bus.value  = v.value;
    bus.dp_pos = v.dp;
    bus.err_in = v.err;
    sb_q.push_back(v);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_conv(input vec_t v);
    int n;
    int d0;
    d0 = done_cnt;
    drive_start(v);
    wait_idle(n);
    check($sformatf("busy_cycles_%0d", v.value), 32'(n), 32'd15);
    repeat (2) @(negedge clk);
    check($sformatf("done_once_%0d", v.value), 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n;
    int   d0;
    vec_t v;

    vecs[0] = '{14'd1234,  2'd0, 1'b0, 16'h1234, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{14'd5,     2'd2, 1'b0, 16'h0005, 4'b1000, 4'b0100, 4'b0000};
    vecs[2] = '{14'd10000, 2'd0, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b1111};
    vecs[3] = '{14'd9999,  2'd0, 1'b1, 16'h0000, 4'b0000, 4'b0000, 4'b1111};
    vecs[4] = '{14'd9999,  2'd0, 1'b0, 16'h9999, 4'b0000, 4'b0000, 4'b0000};
    vecs[5] = '{14'd0,     2'd0, 1'b0, 16'h0000, 4'b1110, 4'b0000, 4'b0000};
    vecs[6] = '{14'd42,    2'd0, 1'b0, 16'h0042, 4'b1100, 4'b0000, 4'b0000};
    vecs[7] = '{14'd100,   2'd1, 1'b0, 16'h0100, 4'b1000, 4'b0010, 4'b0000};
    vecs[8] = '{14'd16383, 2'd3, 1'b0, 16'h0000, 4'b0000, 4'b0000, 4'b1111};
    vecs[9] = '{14'd9,     2'd3, 1'b0, 16'h0009, 4'b0000, 4'b1000, 4'b0000};

    bus.start  = 1'b0;
    bus.value  = '0;
    bus.dp_pos = '0;
    bus.err_in = 1'b0;
    reset      = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("in_reset");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("after_reset");

    for (int i = 0; i < 10; i++) begin
      do_conv(vecs[i]);
    end

    // A second start three cycles in is dropped; inputs moving mid-conversion are ignored.
    d0 = done_cnt;
    drive_start(vecs[6]);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.value = 14'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(n);
    repeat (4) @(negedge clk);
    check("ignored_start_done_count", 32'(done_cnt - d0), 32'd1);
    check("ignored_start_queue_empty", 32'(sb_q.size()), 32'd0);

    // Start issued in the very cycle done is high must be accepted.
    d0 = done_cnt;
    drive_start(vecs[0]);
    n = 0;
    while (!bus.done && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("b2b_done_seen", 32'(bus.done), 32'd1);
    drive_start(vecs[1]);
    wait_idle(n);
    check("b2b_busy_cycles", 32'(n), 32'd15);
    repeat (2) @(negedge clk);
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // Reset in the middle of a conversion wipes everything at once.
    v = '{14'd8888, 2'd0, 1'b0, 16'h8888, 4'b0000, 4'b0000, 4'b0000};
    drive_start(v);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("mid_reset");
    sb_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check_reset_state("post_mid_reset");
    do_conv('{14'd17, 2'd0, 1'b0, 16'h0017, 4'b1100, 4'b0000, 4'b0000});

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_bcd_formatter.md
Name: disp_bcd_formatter

Overview:
- Upstream feeder for the 4-digit multiplexed display controller.
- Converts an unsigned binary calculator result into four BCD digits using sequential double-dabble, one shift per clock.
- Generates per-digit blank (leading-zero suppression), decimal-point and error vectors.
- Holds all outputs stable between conversions, so the display never shows intermediate values.

Parameters:
- WIDTH, 14, bit width of `value`; legal range 14..16; also sets iteration count.
- MAX_VAL, 9999, largest displayable value; anything above is an overflow error.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; samples `value`, `dp_pos`, `err_in`.
- value  input  WIDTH  unsigned binary result to display.
- dp_pos  input  2  index of the digit carrying the decimal point; 0 = no point shown.
- err_in  input  1  upstream error flag, e.g. divide by zero.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when outputs are updated.
- dig0, dig1, dig2, dig3  output  4 each  BCD digits; dig0 = least significant.
- blank  output  4  bit i = 1 blanks dig i.
- dec_point  output  4  bit i = 1 lights the point of dig i.
- error  output  4  bit i = 1 shows the error glyph on dig i.

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - Digits all 0.
  - blank=4'b1110, so a single 0 is displayed.
  - dec_point=0, error=0, busy=0, done=0.
  - Shift register and iteration counter cleared.
- States:
  - IDLE: wait for start.
  - SHIFT: WIDTH iterations.
  - FORMAT: one cycle, then back to IDLE.
- IDLE, start=1 at edge k:
  - Latch value, dp_pos and err_in.
  - Clear BCD accumulator; counter = WIDTH-1.
  - Go to SHIFT; busy=1 from edge k.
- SHIFT, each edge:
  - Apply add-3 correction to every BCD nibble that is >= 5.
  - Shift {bcd, bin} left by 1.
  - Decrement counter; on counter==0 go to FORMAT.
  - Occupies edges k+1..k+WIDTH.
- FORMAT, edge k+WIDTH+1:
  - Register all display outputs; done=1 for exactly one cycle; busy=0; go to IDLE.
  - Latency from start edge to output update is WIDTH+1 edges (15 for WIDTH=14).
- Overflow / error: if latched value > MAX_VAL or latched err_in=1:
  - error=4'b1111, all digits 0, blank=0000, dec_point=0000.
  - BCD thousands nibble overflow beyond 9 never reaches the digit outputs.
- Decimal point: dec_point = one-hot(dp_pos) when dp_pos != 0, else 0000.
- Blanking: dig i (i >= 1) is blanked iff i > dp_pos and dig i..dig3 are all 0.
  - dig0 is never blanked.
  - No digit at or right of the decimal point is ever blanked.
- Arithmetic: accumulator is 16 bits (4 nibbles) plus 1 guard bit for WIDTH=16 overflow detection. Overflow is compared on the latched binary, not on the BCD.
- start while busy=1 (SHIFT or FORMAT): ignored, not queued.
- start in the same cycle done=1: accepted, since state is already IDLE.
- Reset mid-conversion: immediate return to reset values; a partial result is never visible.
- Input changes during SHIFT have no effect, because inputs are latched at start.

Decomposition:
- Shared package:
  - NUM_DIGITS=4, MAX_VAL=9999, ERR_ALL=4'b1111.
  - State encoding localparams ST_IDLE, ST_SHIFT, ST_FORMAT.
  - The same constants are used by disp_controll's instantiating top.
- One natural sub-module: bcd_add3, a combinational nibble correction (in >= 5 ? in+3 : in). It is instantiated once per BCD nibble inside the shift datapath.

Test Plan:
- Reset held, then released with no start -> dig3..0=0,0,0,0, blank=1110, dec_point=0000, error=0000, busy=0.
- start with value=1234, dp_pos=0 -> busy=1 for 15 cycles, done pulse once; dig3..0=1,2,3,4, blank=0000, dec_point=0000, error=0000.
- value=5, dp_pos=2 -> dig3..0=0,0,0,5, blank=1000, dec_point=0100 (reads "0.05").
- value=10000 -> error=1111, blank=0000, digits 0. Then value=9999, err_in=1 -> error=1111. Then value=9999, err_in=0 -> 9,9,9,9, error=0000.
- start=1 again 3 cycles into a conversion with value=7 -> ignored; the first result (e.g. 42 -> blank=1100, dig1..0=4,2) is output and done pulses once.
- reset asserted at cycle 8 of a conversion of 8888 -> outputs return to reset values at once. After release, start with value=17 -> dig1..0=1,7, blank=1100.
